// File: rtl/dbus_pkg.sv
// Shared types for the data-bus responder: access size, byte strobes and the
// in-order response queue entry. Used with or without DBUS_RESP_STALL_EN.
package dbus_pkg;

  // Width of the per-entry countdown; covers latencies 1..8 (count 0..7).
  localparam int RESP_CNT_W = 3;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef logic [3:0] strobe_t;

  typedef struct packed {
    logic                  is_load;
    logic [31:0]           data;
    logic [RESP_CNT_W-1:0] count;
  } resp_entry_t;

  // Raw size field to access size; the reserved encoding 3 behaves as a word.
  function automatic msize_t decode_size(input logic [1:0] sz);
    case (sz)
      2'd0:    return MSIZE1;
      2'd1:    return MSIZE2;
      default: return MSIZE4;
    endcase
  endfunction

  // Byte lanes written by a store. Halfwords only look at addr[1] and words
  // ignore the low address bits, so misaligned accesses never trap here.
  function automatic strobe_t gen_strobe(input msize_t sz, input logic [1:0] a);
    case (sz)
      MSIZE1:  return strobe_t'(4'b0001 << a);
      MSIZE2:  return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// SRAM-like data-bus handshake between the memory stage (master) and the
// responder (slave).
interface dbus_sram_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/dbus_resp_fifo.sv
// In-order outstanding-request queue with a countdown per entry. An entry is
// pushed with its count preset; the head may pop once its count reaches 0.
// Load data arrives one cycle after the push (registered RAM read) through
// fill_i, and is bypassed to head_out_o if the head is that very entry.
module dbus_resp_fifo
  import dbus_pkg::*;
#(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push_i,
  input  resp_entry_t entry_in_i,
  input  logic        fill_i,
  input  logic [31:0] fill_data_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        head_ready_o,
  output resp_entry_t head_out_o
);

  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int OCC_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, fill_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [OUTSTANDING-1:0][RESP_CNT_W-1:0] cnt_q, cnt_d;
  logic        is_load_q [OUTSTANDING];
  logic [31:0] data_q    [OUTSTANDING];

  logic head_valid, do_push, do_pop;

  assign full_o       = (occ_q == OCC_W'(OUTSTANDING));
  assign head_valid   = (occ_q != '0);
  assign head_ready_o = head_valid && (cnt_q[rd_ptr_q] == '0);
  assign do_push      = push_i && !full_o;
  assign do_pop       = pop_i && head_ready_o;

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    occ_d = occ_q;
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Per-entry countdown: preload on push, otherwise step towards zero.
  genvar gi;
  generate
    for (gi = 0; gi < OUTSTANDING; gi++) begin : g_cnt
      assign cnt_d[gi] = (do_push && (wr_ptr_q == PTR_W'(gi))) ? entry_in_i.count :
                         (cnt_q[gi] != '0)                     ? cnt_q[gi] - 1'b1 :
                                                                 cnt_q[gi];
    end
  endgenerate

  // Control state; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_ptr_q <= '0;
      occ_q      <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      if (do_push) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        fill_ptr_q <= wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Payload storage; the fill targets the slot pushed one cycle earlier,
  // which can never be the slot being pushed now.
  always_ff @(posedge clk) begin
    if (do_push) begin
      is_load_q[wr_ptr_q] <= entry_in_i.is_load;
      data_q[wr_ptr_q]    <= entry_in_i.data;
    end
    if (fill_i) begin
      data_q[fill_ptr_q] <= fill_data_i;
    end
  end

  // Head view, with the late load word bypassed when it belongs to the head.
  always_comb begin
    head_out_o         = '0;
    head_out_o.is_load = is_load_q[rd_ptr_q];
    head_out_o.count   = cnt_q[rd_ptr_q];
    if (fill_i && (rd_ptr_q == fill_ptr_q)) begin
      head_out_o.data = fill_data_i;
    end else begin
      head_out_o.data = data_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// Responder end of the SRAM-like data bus: word-addressed RAM with byte
// strobes, fixed response latency and an in-order outstanding queue.
// Optional macro DBUS_RESP_STALL_EN adds LFSR-driven random backpressure
// on addr_ok; without it addr_ok is simply "queue not full".
module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int DEPTH_LOG2  = 12,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  dbus_sram_responder_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                  accept;
  logic                  full;
  logic                  head_ready;
  logic [DEPTH_LOG2-1:0] ram_idx;
  msize_t                size_dec;
  strobe_t               strb;
  resp_entry_t           entry_in;
  resp_entry_t           head_out;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;
  logic        fill_q;

  assign accept   = bus.req && bus.addr_ok;
  // Upper address bits are dropped, so the RAM aliases modulo its size.
  assign ram_idx  = bus.addr[DEPTH_LOG2+1:2];
  assign size_dec = decode_size(bus.size);
  assign strb     = gen_strobe(size_dec, bus.addr[1:0]);

  // RAM port: byte-lane store at the accept edge, registered load read.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) begin
          mem[ram_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
    if (accept && !bus.wr) begin
      rd_q <= mem[ram_idx];
    end
  end

  // Marks that rd_q holds the word for the entry pushed last cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_q <= 1'b0;
    end else begin
      fill_q <= accept && !bus.wr;
    end
  end

  // Load data is filled in next cycle; stores respond with zero.
  always_comb begin
    entry_in         = '0;
    entry_in.is_load = !bus.wr;
    entry_in.count   = RESP_CNT_W'(LATENCY - 1);
  end

  dbus_resp_fifo #(
    .OUTSTANDING (OUTSTANDING)
  ) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push_i       (accept),
    .entry_in_i   (entry_in),
    .fill_i       (fill_q),
    .fill_data_i  (rd_q),
    .pop_i        (head_ready),
    .full_o       (full),
    .head_ready_o (head_ready),
    .head_out_o   (head_out)
  );

  assign bus.data_ok = head_ready;
  assign bus.rdata   = (head_ready && head_out.is_load) ? head_out.data : 32'h0;

`ifdef DBUS_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running every cycle.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // LFSR state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Roughly one cycle in four is refused even with space in the queue.
  assign bus.addr_ok = !full && (lfsr_q[1:0] != 2'b00);
`else
  // No same-cycle bypass: a pop while full frees a slot only next cycle.
  assign bus.addr_ok = !full;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.addr[31:DEPTH_LOG2+2], head_out.count};

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Self-checking bench for dbus_sram_responder: directed vector table on a
// LATENCY=2 instance, hand sequences on a LATENCY=8 instance, and a
// scoreboarded random run.
module tb_dbus_sram_responder;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  dbus_sram_responder_if bus_a ();
  dbus_sram_responder_if bus_b ();

  dbus_sram_responder #(.DEPTH_LOG2(12), .LATENCY(2), .OUTSTANDING(4)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_a)
  );

  dbus_sram_responder #(.DEPTH_LOG2(12), .LATENCY(8), .OUTSTANDING(4)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_ok;
    logic        exp_dok;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          acc;
  } exp_t;

  vec_t        tbl [21];
  exp_t        sbq [$];
  logic [31:0] model [64];
  int          n_acc  = 0;
  int          n_resp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] tb_strobe(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] one;
    one = 4'b0001;
    if (sz == 2'd0) return one << off;
    if (sz == 2'd1) return off[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // One scoreboard cycle on dut_a: check any response, then record an accept.
  task automatic sb_cycle(output logic accepted);
    exp_t        e;
    logic [3:0]  st;
    int          idx;
    accepted = 1'b0;
    @(negedge clk);
    if (bus_a.data_ok) begin
      if (sbq.size() == 0) begin
        check("sb_spurious_data_ok", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("sb_rdata", bus_a.rdata, e.data);
        check("sb_latency", 32'(cyc), 32'(e.acc + 2));
        n_resp++;
      end
    end else begin
      check("sb_idle_rdata", bus_a.rdata, 32'h0);
    end
    if (bus_a.req && bus_a.addr_ok) begin
      accepted = 1'b1;
      idx = int'(bus_a.addr[7:2]);
      e.acc = cyc;
      if (bus_a.wr) begin
        e.data = 32'h0;
        st = tb_strobe(bus_a.size, bus_a.addr[1:0]);
        for (int b = 0; b < 4; b++)
          if (st[b]) model[idx][8*b +: 8] = bus_a.wdata[8*b +: 8];
      end else begin
        e.data = model[idx];
      end
      sbq.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  // Hold a request on dut_b until accepted (bounded).
  task automatic issue_b(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic acc;
    acc = 1'b0;
    bus_b.req = 1'b1; bus_b.wr = wr; bus_b.size = 2'd2;
    bus_b.addr = addr; bus_b.wdata = wdata;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk);
      acc = bus_b.addr_ok;
      @(posedge clk);
      #1;
    end
    if (!acc) check("issue_b_accept_timeout", 32'd0, 32'd1);
    bus_b.req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, no summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [21:0] ok_mask, dok_mask;
    logic [31:0] rnd, a;
    int          k, j;

    bus_a.req = 0; bus_a.wr = 0; bus_a.size = 0; bus_a.addr = 0; bus_a.wdata = 0;
    bus_b.req = 0; bus_b.wr = 0; bus_b.size = 0; bus_b.addr = 0; bus_b.wdata = 0;

    // Test 1: reset, then idle.
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

`ifndef DBUS_RESP_STALL_EN
    @(negedge clk);
    check("rst_addr_ok", 32'(bus_a.addr_ok), 32'd1);
    check("rst_data_ok", 32'(bus_a.data_ok), 32'd0);
    check("rst_rdata", bus_a.rdata, 32'h0);
    check("rst_b_addr_ok", 32'(bus_b.addr_ok), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_data_ok", 32'(bus_a.data_ok), 32'd0);
      @(posedge clk); #1;
    end

    // Tests 2, 3, 5 plus size/misalignment cases, one row per cycle.
    tbl[0]  = '{1'b1, 1'b1, 2'd2, 32'h100,  32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 2'd2, 32'h100,  32'h0,        1'b1, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
    tbl[4]  = '{1'b1, 1'b1, 2'd2, 32'h40,   32'h0,        1'b1, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 2'd0, 32'h42,   32'h00AB0000, 1'b1, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 2'd1, 32'h40,   32'h0000CDEF, 1'b1, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 2'd2, 32'h40,   32'h0,        1'b1, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h00ABCDEF};
    tbl[10] = '{1'b1, 1'b1, 2'd2, 32'h4004, 32'h12345678, 1'b1, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 2'd2, 32'h4,    32'h0,        1'b1, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h0};
    tbl[13] = '{1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h12345678};
    tbl[14] = '{1'b1, 1'b1, 2'd3, 32'h203,  32'hCAFEF00D, 1'b1, 1'b0, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 2'd0, 32'h200,  32'h0,        1'b1, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h0};
    tbl[17] = '{1'b1, 1'b1, 2'd1, 32'h203,  32'h5A5A0000, 1'b1, 1'b1, 32'hCAFEF00D};
    tbl[18] = '{1'b1, 1'b0, 2'd1, 32'h202,  32'h0,        1'b1, 1'b0, 32'h0};
    tbl[19] = '{1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h0};
    tbl[20] = '{1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h5A5AF00D};

    for (int i = 0; i < 21; i++) begin
      bus_a.req = tbl[i].req; bus_a.wr = tbl[i].wr; bus_a.size = tbl[i].size;
      bus_a.addr = tbl[i].addr; bus_a.wdata = tbl[i].wdata;
      @(negedge clk);
      $display("vec %0d req=%0d wr=%0d size=%0d addr=%08h addr_ok=%0d data_ok=%0d rdata=%08h",
               i, tbl[i].req, tbl[i].wr, tbl[i].size, tbl[i].addr,
               bus_a.addr_ok, bus_a.data_ok, bus_a.rdata);
      check($sformatf("vec%0d_addr_ok", i), 32'(bus_a.addr_ok), 32'(tbl[i].exp_ok));
      check($sformatf("vec%0d_data_ok", i), 32'(bus_a.data_ok), 32'(tbl[i].exp_dok));
      check($sformatf("vec%0d_rdata", i), bus_a.rdata, tbl[i].exp_rdata);
      @(posedge clk); #1;
    end
    bus_a.req = 1'b0;

    // Test 4: LATENCY=8, OUTSTANDING=4, req held high for 8 loads.
    for (int i = 0; i < 8; i++) issue_b(1'b1, 32'(i * 4), 32'hC0DE0000 | 32'(i));
    repeat (20) @(posedge clk);
    #1;
    ok_mask  = 22'h3C1E0F;
    dok_mask = 22'h1E0F00;
    k = 0; j = 0;
    for (int o = 0; o < 22; o++) begin
      bus_b.req = (k < 8); bus_b.wr = 1'b0; bus_b.size = 2'd2; bus_b.addr = 32'(k * 4);
      @(negedge clk);
      check($sformatf("t4_addr_ok_c%0d", o), 32'(bus_b.addr_ok), 32'(ok_mask[o]));
      check($sformatf("t4_data_ok_c%0d", o), 32'(bus_b.data_ok), 32'(dok_mask[o]));
      if (bus_b.data_ok) begin
        $display("t4 resp %0d rdata=%08h", j, bus_b.rdata);
        check($sformatf("t4_rdata_%0d", j), bus_b.rdata, 32'hC0DE0000 | 32'(j));
        j++;
      end
      if (bus_b.req && bus_b.addr_ok) k++;
      @(posedge clk); #1;
    end
    bus_b.req = 1'b0;
    check("t4_resp_count", 32'(j), 32'd8);

    // Test 6: reset with three loads in flight.
    for (int i = 0; i < 3; i++) begin
      bus_b.req = 1'b1; bus_b.wr = 1'b0; bus_b.addr = 32'(i * 4);
      @(negedge clk);
      check("t6_accept", 32'(bus_b.addr_ok), 32'd1);
      @(posedge clk); #1;
    end
    bus_b.req = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t6_no_data_ok", 32'(bus_b.data_ok), 32'd0);
      check("t6_addr_ok", 32'(bus_b.addr_ok), 32'd1);
      @(posedge clk); #1;
    end
`endif

    // Random run on dut_a: preload 64 words, then 1000 mixed requests.
    for (int w = 0; w < 64; w++) begin
      rnd = $urandom();
      a = {rnd[31:14], 6'b0, 6'(w), 2'b00};
      bus_a.req = 1'b1; bus_a.wr = 1'b1; bus_a.size = 2'd2; bus_a.addr = a;
      bus_a.wdata = $urandom();
      acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++) sb_cycle(acc);
      if (!acc) check("preload_accept_timeout", 32'd0, 32'd1);
    end
    for (int n = 0; n < 1000; n++) begin
      rnd = $urandom();
      a = {rnd[31:14], 6'b0, rnd[7:0]};
      bus_a.req = 1'b1; bus_a.wr = rnd[8]; bus_a.size = rnd[10:9];
      bus_a.addr = a; bus_a.wdata = $urandom();
      acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++) sb_cycle(acc);
      if (!acc) check("rand_accept_timeout", 32'd0, 32'd1);
      bus_a.req = 1'b0;
      if (rnd[11]) sb_cycle(acc);
    end
    bus_a.req = 1'b0;
    for (int t = 0; t < 20; t++) sb_cycle(acc);
    $display("random run: %0d accepts, %0d responses", n_acc, n_resp);
    check("rand_resp_count", 32'(n_resp), 32'(n_acc));
    check("rand_queue_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
